pixel_binariser: RTL
====================

// Module: pixel_binariser
// PURPOSE
//  Pixel-clock front end of the player: converts 24-bit RGB video into the 1-bit Pixel stream the
//  fret detectors sample. Luma threshold, optional invert, 3-tap horizontal majority despeckle.
//  Emits HSync/VSync/VDE delayed to stay aligned with Pixel; all outputs feed player_filtered.
// PARAMETERS
//  DEFAULT_THRESH  8'd128  threshold loaded at reset, used until first frame-start capture
//  COUNT_W         20      lit-pixel counter width (BINARISER_STATS_EN only)
// PORTS
//  CLK         in   1        pixel clock (PClk); all logic on posedge
//  RST_N       in   1        asynchronous, active-low reset
//  RGB         in   24       {R[23:16],G[15:8],B[7:0]}, valid when VDE_in=1
//  HSync_in    in   1        horizontal sync, active high
//  VSync_in    in   1        vertical sync, active high
//  VDE_in      in   1        video data enable
//  Thresh      in   8        luma threshold (software register)
//  Invert      in   1        1: lit = luma <= Thresh
//  FilterEn    in   1        1: majority filter on; 0: bypass
//  HSync       out  1        HSync_in delayed 4 cycles
//  VSync       out  1        VSync_in delayed 4 cycles
//  VDE         out  1        VDE_in delayed 4 cycles
//  Pixel       out  1        binarised pixel, aligned with VDE
//  LitCount    out  COUNT_W  lit pixels in last frame (BINARISER_STATS_EN only)
//  FrameDone   out  1        1-cycle pulse when LitCount updates (BINARISER_STATS_EN only)
// BEHAVIOUR
//  Reset: every output and pipeline register 0; threshold shadow = DEFAULT_THRESH; no X on outputs.
//  Latency: fixed 4 cycles, input to Pixel/HSync/VSync/VDE; no stalls, no handshake, 1 pixel/cycle.
//  S1: luma = (2R + 5G + B) >> 3. Sum is 11 bits (max 2040), luma 8 bits (max 255); truncate.
//  S2: bit = VDE_s1 & (Invert ? luma <= th : luma > th). Blanking always 0, regardless of Invert.
//  S3: 3-deep window b0 (newest), b1, b2 with VDE tags; centre = b1.
//   Neighbour with VDE tag 0 (line edge) is replaced by centre value (edge replicate).
//   FilterEn=1: out = maj(b0,b1,b2); FilterEn=0: out = b1. FilterEn acts immediately, no added delay.
//  S4: output register. Pixel = out & VDE_s3.
//  Threshold: th is shadow of Thresh, captured on the cycle a VSync_in rising edge is detected
//   (VSync_in=1, previous sample 0). Mid-frame Thresh writes have no effect until next frame start.
//   Invert is sampled with the same rule as Thresh.
//  VSync held high over many lines -> exactly one capture per rising edge.
//  Async reset mid-line: outputs drop to 0 immediately. After release the pipeline refills;
//   the first 4 outputs are 0.
// CONFIGURATION
//  BINARISER_STATS_EN defined: counter += 1 per cycle with VDE=1 & Pixel=1, saturating at 2^COUNT_W-1.
//   Rising edge of output VSync: LitCount <= counter, FrameDone pulses 1 cycle, counter <= 0.
//   Lit pixel on that same cycle is not counted. Reset: LitCount=0, FrameDone=0.
//  BINARISER_STATS_EN undefined: LitCount/FrameDone ports and counter logic absent.
//   Pixel path is identical in both builds.
// TESTING
//  1. Reset, Thresh=128, FilterEn=0, VDE_in=1, RGB=FFFFFF -> Pixel=1 exactly 4 cycles later; HSync/VSync/VDE track input at 4 cycles.
//  2. RGB=808080, Thresh=128 -> luma 128, Pixel=0; Invert=1 (after VSync edge) -> Pixel=1; VDE_in=0 -> Pixel=0 either polarity.
//  3. Dark line, single FFFFFF pixel mid-line: FilterEn=1 -> no Pixel=1; FilterEn=0 -> single 1. Lit first pixel of line with lit neighbour survives (edge replicate).
//  4. Thresh 128->250 mid-frame with RGB=C8C8C8 (luma 200) -> Pixel stays 1 to frame end, 0 from first line after next VSync rise.
//  5. Assert RST_N=0 mid-line with Pixel=1 -> all outputs 0 same cycle; after release, first 4 outputs 0, then correct.
//  6. STATS_EN: frame with 300 isolated-free lit pixels -> LitCount=300, one FrameDone pulse; 1920x1080 all lit -> LitCount=1048575 (saturated).

Source files
------------

// File: rtl/pixel_binariser.sv
// pixel_binariser: 24-bit RGB -> 1-bit lit pixel (luma threshold, optional invert, 3-tap majority
// despeckle), syncs delayed 4 cycles to match. Frame statistics built only with BINARISER_STATS_EN.
module pixel_binariser #(
    parameter logic [7:0] DEFAULT_THRESH = 8'd128
`ifdef BINARISER_STATS_EN
    ,
    parameter int         COUNT_W        = 20
`endif
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] RGB,
    input  logic        HSync_in,
    input  logic        VSync_in,
    input  logic        VDE_in,
    input  logic [7:0]  Thresh,
    input  logic        Invert,
    input  logic        FilterEn,
    output logic        HSync,
    output logic        VSync,
    output logic        VDE,
    output logic        Pixel
`ifdef BINARISER_STATS_EN
    ,
    output logic [COUNT_W-1:0] LitCount,
    output logic               FrameDone
`endif
);

    function automatic logic [7:0] f_luma(input logic [23:0] rgb);
        logic [10:0] sum;
        sum = 11'({rgb[23:16], 1'b0})
            + 11'({rgb[15:8], 2'b00}) + 11'(rgb[15:8])
            + 11'(rgb[7:0]);
        return sum[10:3];
    endfunction

    function automatic logic f_lit(input logic [7:0] luma, input logic [7:0] th, input logic inv);
        return inv ? (luma <= th) : (luma > th);
    endfunction

    function automatic logic f_maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Threshold/invert shadows, reloaded only at a VSync_in rising edge
    logic       r_vs_in_d;
    logic [7:0] r_th;
    logic       r_inv;
    logic       w_frame_start;

    assign w_frame_start = VSync_in & ~r_vs_in_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vs_in_d <= 1'b0;
            r_th      <= DEFAULT_THRESH;
            r_inv     <= 1'b0;
        end else begin
            r_vs_in_d <= VSync_in;
            if (w_frame_start) begin
                r_th  <= Thresh;
                r_inv <= Invert;
            end
        end
    end

    logic [7:0] r_luma_p1;
    logic       r_vde_p1, r_hs_p1, r_vs_p1;
    logic       r_bit_p2, r_vde_p2, r_hs_p2, r_vs_p2;
    logic       r_bit_p3, r_vde_p3, r_bit_p3d, r_vde_p3d, r_hs_p3, r_vs_p3;
    logic       r_pix_p4, r_vde_p4, r_hs_p4, r_vs_p4;
    logic       w_nb_new, w_nb_old, w_filt, w_pix;

    // S1: luma
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_luma_p1 <= 8'd0;
            r_vde_p1  <= 1'b0;
            r_hs_p1   <= 1'b0;
            r_vs_p1   <= 1'b0;
        end else begin
            r_luma_p1 <= f_luma(RGB);
            r_vde_p1  <= VDE_in;
            r_hs_p1   <= HSync_in;
            r_vs_p1   <= VSync_in;
        end
    end

    // S2: threshold; blanking forces 0 whatever the polarity
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_p2 <= 1'b0;
            r_vde_p2 <= 1'b0;
            r_hs_p2  <= 1'b0;
            r_vs_p2  <= 1'b0;
        end else begin
            r_bit_p2 <= r_vde_p1 & f_lit(r_luma_p1, r_th, r_inv);
            r_vde_p2 <= r_vde_p1;
            r_hs_p2  <= r_hs_p1;
            r_vs_p2  <= r_vs_p1;
        end
    end

    // S3: window b0 = r_bit_p2 (newest), b1 = r_bit_p3 (centre), b2 = r_bit_p3d
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_p3  <= 1'b0;
            r_vde_p3  <= 1'b0;
            r_bit_p3d <= 1'b0;
            r_vde_p3d <= 1'b0;
            r_hs_p3   <= 1'b0;
            r_vs_p3   <= 1'b0;
        end else begin
            r_bit_p3  <= r_bit_p2;
            r_vde_p3  <= r_vde_p2;
            r_bit_p3d <= r_bit_p3;
            r_vde_p3d <= r_vde_p3;
            r_hs_p3   <= r_hs_p2;
            r_vs_p3   <= r_vs_p2;
        end
    end

    // Neighbours outside the active line take the centre value (edge replicate)
    assign w_nb_new = r_vde_p2  ? r_bit_p2  : r_bit_p3;
    assign w_nb_old = r_vde_p3d ? r_bit_p3d : r_bit_p3;
    assign w_filt   = FilterEn ? f_maj(w_nb_new, r_bit_p3, w_nb_old) : r_bit_p3;
    assign w_pix    = w_filt & r_vde_p3;

    // S4: output register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix_p4 <= 1'b0;
            r_vde_p4 <= 1'b0;
            r_hs_p4  <= 1'b0;
            r_vs_p4  <= 1'b0;
        end else begin
            r_pix_p4 <= w_pix;
            r_vde_p4 <= r_vde_p3;
            r_hs_p4  <= r_hs_p3;
            r_vs_p4  <= r_vs_p3;
        end
    end

    assign Pixel = r_pix_p4;
    assign VDE   = r_vde_p4;
    assign HSync = r_hs_p4;
    assign VSync = r_vs_p4;

`ifdef BINARISER_STATS_EN
    function automatic logic [COUNT_W-1:0] f_sat_inc(input logic [COUNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic               r_vs_out_d;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] r_lit_count;
    logic               r_frame_done;
    logic               w_vs_rise;

    assign w_vs_rise = r_vs_p4 & ~r_vs_out_d;

    // The lit pixel coinciding with the VSync rise belongs to neither frame
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vs_out_d   <= 1'b0;
            r_count      <= '0;
            r_lit_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_vs_out_d <= r_vs_p4;
            if (w_vs_rise) begin
                r_lit_count  <= r_count;
                r_frame_done <= 1'b1;
                r_count      <= '0;
            end else begin
                r_frame_done <= 1'b0;
                if (r_vde_p4 & r_pix_p4)
                    r_count <= f_sat_inc(r_count);
            end
        end
    end

    assign LitCount  = r_lit_count;
    assign FrameDone = r_frame_done;
`endif

endmodule
